// File: rtl/handshake_coef_pkg.sv
// rtl/handshake_coef_pkg.sv - shared coefficient table, state type and index-width helper for handshake_coef_sequencer
package handshake_coef_pkg;

  localparam int COEF_W     = 12;
  localparam int COEF_DEPTH = 16;

  // Sequencer states: IDLE waits for a control token, BURST streams the table.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } seq_state_t;

  // tanh soft-clip polynomial coefficients; unused tail entries are zero.
  localparam logic [COEF_W-1:0] COEF_TABLE [COEF_DEPTH] = '{
    12'hFAF, 12'h040, 12'h800, 12'h155,
    12'h000, 12'h000, 12'h000, 12'h000,
    12'h000, 12'h000, 12'h000, 12'h000,
    12'h000, 12'h000, 12'h000, 12'h000
  };

  // Index width for a burst of n coefficients; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/handshake_coef_rom.sv
// rtl/handshake_coef_rom.sv - combinational coefficient lookup, kept apart so the table can be regenerated
module handshake_coef_rom
  import handshake_coef_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int IDX_WIDTH  = 2
) (
  input  logic [IDX_WIDTH-1:0]  i_idx,
  output logic [DATA_WIDTH-1:0] o_coef
);

  logic [3:0] w_addr;

  assign w_addr = 4'(i_idx);

  // Pure table lookup; no state lives here.
  always_comb begin
    o_coef = DATA_WIDTH'(COEF_TABLE[w_addr]);
  end

endmodule

// File: rtl/handshake_coef_sequencer.sv
// rtl/handshake_coef_sequencer.sv - per-token coefficient burst source; HANDSHAKE_COEF_SEQ_LAST_EN adds outs_last
module handshake_coef_sequencer
  import handshake_coef_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_COEF   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  busy
`ifdef HANDSHAKE_COEF_SEQ_LAST_EN
  ,
  output logic                  outs_last
`endif
);

  localparam int IDX_WIDTH = idx_width(NUM_COEF);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_COEF - 1);

  seq_state_t           r_state;
  logic [IDX_WIDTH-1:0] r_idx;
  logic                 r_outs_valid;
  logic                 r_busy;

  logic w_last_beat;
  logic w_ctrl_ready;
  logic w_ctrl_fire;
  logic w_outs_fire;

  assign w_last_beat = (r_idx == LAST_IDX);

  // Accept a token when idle, or on the last beat being taken so bursts chain without a bubble.
  always_comb begin
    w_ctrl_ready = 1'b0;
    if (!rst) begin
      w_ctrl_ready = (r_state == IDLE) ||
                     ((r_state == BURST) && w_last_beat && outs_ready);
    end
  end

  assign w_ctrl_fire = ctrl_valid && w_ctrl_ready;
  assign w_outs_fire = r_outs_valid && outs_ready;

  // Burst FSM: idx only moves on an output handshake, so outs is stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_outs_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ctrl_fire) begin
            r_state      <= BURST;
            r_idx        <= '0;
            r_outs_valid <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        BURST: begin
          if (w_outs_fire) begin
            if (!w_last_beat) begin
              r_idx <= r_idx + IDX_WIDTH'(1);
            end else if (w_ctrl_fire) begin
              r_idx <= '0;
            end else begin
              r_state      <= IDLE;
              r_idx        <= '0;
              r_outs_valid <= 1'b0;
              r_busy       <= 1'b0;
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_idx        <= '0;
          r_outs_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  handshake_coef_rom #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_rom (
    .i_idx  (r_idx),
    .o_coef (outs)
  );

  assign ctrl_ready = w_ctrl_ready;
  assign outs_valid = r_outs_valid;
  assign busy       = r_busy;

`ifdef HANDSHAKE_COEF_SEQ_LAST_EN
  assign outs_last = r_outs_valid && w_last_beat;
`endif

endmodule

// File: tb/tb_handshake_coef_sequencer.sv
// tb/tb_handshake_coef_sequencer.sv - directed self-checking bench for handshake_coef_sequencer
module tb_handshake_coef_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic [11:0] outs;
  logic        outs_valid;
  logic        outs_ready;
  logic        busy;
  logic        outs_last;

  logic        ctrl_valid_b;
  logic        ctrl_ready_b;
  logic [11:0] outs_b;
  logic        outs_valid_b;
  logic        outs_ready_b;
  logic        busy_b;
  logic        outs_last_b;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_seq [4];

  always #5 clk = ~clk;

  handshake_coef_sequencer #(.DATA_WIDTH(12), .NUM_COEF(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .busy       (busy)
`ifdef HANDSHAKE_COEF_SEQ_LAST_EN
    ,
    .outs_last  (outs_last)
`endif
  );

  handshake_coef_sequencer #(.DATA_WIDTH(12), .NUM_COEF(1)) dut_one (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid_b),
    .ctrl_ready (ctrl_ready_b),
    .outs       (outs_b),
    .outs_valid (outs_valid_b),
    .outs_ready (outs_ready_b),
    .busy       (busy_b)
`ifdef HANDSHAKE_COEF_SEQ_LAST_EN
    ,
    .outs_last  (outs_last_b)
`endif
  );

`ifndef HANDSHAKE_COEF_SEQ_LAST_EN
  assign outs_last   = 1'b0;
  assign outs_last_b = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_seq[0] = 12'hFAF;
    exp_seq[1] = 12'h040;
    exp_seq[2] = 12'h800;
    exp_seq[3] = 12'h155;

    rst = 1'b1; ctrl_valid = 1'b0; outs_ready = 1'b0;
    ctrl_valid_b = 1'b0; outs_ready_b = 1'b0;

    // Reset then idle
    step();
    #1 check("rst_ctrl_ready_low", 32'(ctrl_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("idle_outs_valid", 32'(outs_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ctrl_ready", 32'(ctrl_ready), 32'd1);
    check("idle_outs", 32'(outs), 32'hFAF);
    check("idle_last", 32'(outs_last), 32'd0);

    // Single burst
    ctrl_valid = 1'b1; outs_ready = 1'b1;
    step();
    ctrl_valid = 1'b0;
    #1;
    check("single_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("single_outs_%0d", i), 32'(outs), 32'(exp_seq[i]));
      check($sformatf("single_valid_%0d", i), 32'(outs_valid), 32'd1);
      check($sformatf("single_cready_%0d", i), 32'(ctrl_ready), (i == 3) ? 32'd1 : 32'd0);
`ifdef HANDSHAKE_COEF_SEQ_LAST_EN
      check($sformatf("single_last_%0d", i), 32'(outs_last), (i == 3) ? 32'd1 : 32'd0);
`endif
      step();
      #1;
    end
    check("single_end_valid", 32'(outs_valid), 32'd0);
    check("single_end_busy", 32'(busy), 32'd0);

    // Backpressure at idx=2
    ctrl_valid = 1'b1;
    step();
    ctrl_valid = 1'b0;
    step();
    step();
    outs_ready = 1'b0;
    #1;
    check("bp_outs_start", 32'(outs), 32'h800);
    check("bp_cready_idx2", 32'(ctrl_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check($sformatf("bp_hold_outs_%0d", i), 32'(outs), 32'h800);
      check($sformatf("bp_hold_valid_%0d", i), 32'(outs_valid), 32'd1);
      check($sformatf("bp_hold_cready_%0d", i), 32'(ctrl_ready), 32'd0);
    end
    outs_ready = 1'b1;
    step();
    outs_ready = 1'b0;
    #1;
    check("bp_resume_outs", 32'(outs), 32'h155);
    check("bp_last_stalled_cready", 32'(ctrl_ready), 32'd0);
    outs_ready = 1'b1;
    #1;
    check("bp_last_ready_cready", 32'(ctrl_ready), 32'd1);
    step();
    #1 check("bp_end_valid", 32'(outs_valid), 32'd0);

    // Back-to-back bursts
    ctrl_valid = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) ctrl_valid = 1'b0;
      #1;
      check($sformatf("b2b_outs_%0d", i), 32'(outs), 32'(exp_seq[i % 4]));
      check($sformatf("b2b_valid_%0d", i), 32'(outs_valid), 32'd1);
      check($sformatf("b2b_cready_%0d", i), 32'(ctrl_ready), ((i % 4) == 3) ? 32'd1 : 32'd0);
      step();
    end
    #1 check("b2b_end_valid", 32'(outs_valid), 32'd0);

    // Reset mid-burst
    ctrl_valid = 1'b1;
    step();
    ctrl_valid = 1'b0;
    step();
    #1 check("mid_idx1_outs", 32'(outs), 32'h040);
    rst = 1'b1;
    #1 check("mid_rst_cready", 32'(ctrl_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("mid_valid", 32'(outs_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_outs", 32'(outs), 32'hFAF);
    check("mid_cready", 32'(ctrl_ready), 32'd1);
    ctrl_valid = 1'b1;
    step();
    ctrl_valid = 1'b0;
    #1;
    check("mid_restart_outs", 32'(outs), 32'hFAF);
    check("mid_restart_valid", 32'(outs_valid), 32'd1);
    outs_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // NUM_COEF=1 instance
    ctrl_valid_b = 1'b1; outs_ready_b = 1'b1;
    step();
    ctrl_valid_b = 1'b0;
    #1;
    check("one_outs", 32'(outs_b), 32'hFAF);
    check("one_valid", 32'(outs_valid_b), 32'd1);
    check("one_busy", 32'(busy_b), 32'd1);
    check("one_cready_hi", 32'(ctrl_ready_b), 32'd1);
`ifdef HANDSHAKE_COEF_SEQ_LAST_EN
    check("one_last", 32'(outs_last_b), 32'd1);
`endif
    outs_ready_b = 1'b0;
    #1 check("one_cready_lo", 32'(ctrl_ready_b), 32'd0);
    step();
    #1;
    check("one_hold_valid", 32'(outs_valid_b), 32'd1);
    check("one_hold_outs", 32'(outs_b), 32'hFAF);
    outs_ready_b = 1'b1; ctrl_valid_b = 1'b1;
    step();
    ctrl_valid_b = 1'b0;
    #1;
    check("one_b2b_valid", 32'(outs_valid_b), 32'd1);
    check("one_b2b_outs", 32'(outs_b), 32'hFAF);
    step();
    #1 check("one_end_valid", 32'(outs_valid_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
